// File: rtl/ama_riscv_uart.sv
//==============================================================================
// ama_riscv_uart : MMIO UART, 8N1 serializer/deserializer with rv handshakes
// Revision: 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module ama_riscv_uart #(
   parameter int CLK_FREQ  = 100_000_000,
   parameter int BAUD_RATE = 115_200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] send_req_data,
   input  logic       send_req_valid,
   output logic       send_req_ready,
   output logic [7:0] recv_rsp_data,
   output logic       recv_rsp_valid,
   input  logic       recv_rsp_ready,
   input  logic       serial_in,
   output logic       serial_out
);

   localparam int SYM  = CLK_FREQ / BAUD_RATE;
   localparam int HALF = SYM / 2;
   localparam int CW   = $clog2(SYM) + 1;
   localparam logic [CW-1:0] SYM_LAST  = CW'(SYM - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

   generate
      if (SYM < 4) begin : g_sym_check
         $error("ama_riscv_uart: CLK_FREQ/BAUD_RATE must be at least 4");
      end
   endgenerate

   // ---------------------------------------------------------------- TX path
   typedef enum logic [0:0] {
      TX_IDLE  = 1'b0,
      TX_SHIFT = 1'b1
   } tx_state_t;

   tx_state_t     r_tx_state;
   logic [9:0]    r_tx_shreg;
   logic [CW-1:0] r_tx_baud;
   logic [3:0]    r_tx_bit;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_state     <= TX_IDLE;
         r_tx_shreg     <= '1;
         r_tx_baud      <= '0;
         r_tx_bit       <= '0;
         serial_out     <= 1'b1;
         send_req_ready <= 1'b1;
      end else begin
         case (r_tx_state)
            TX_IDLE: begin
               if (send_req_valid) begin
                  r_tx_shreg     <= {1'b1, send_req_data, 1'b0};
                  r_tx_baud      <= '0;
                  r_tx_bit       <= '0;
                  serial_out     <= 1'b0;
                  send_req_ready <= 1'b0;
                  r_tx_state     <= TX_SHIFT;
               end
            end
            TX_SHIFT: begin
               if (r_tx_baud == SYM_LAST) begin
                  r_tx_baud <= '0;
                  if (r_tx_bit == 4'd9) begin
                     serial_out     <= 1'b1;
                     send_req_ready <= 1'b1;
                     r_tx_state     <= TX_IDLE;
                  end else begin
                     // serial_out tracks the new bit 0 of the shifted register
                     r_tx_shreg <= {1'b1, r_tx_shreg[9:1]};
                     serial_out <= r_tx_shreg[1];
                     r_tx_bit   <= r_tx_bit + 4'd1;
                  end
               end else begin
                  r_tx_baud <= r_tx_baud + CW'(1);
               end
            end
            default: begin
               serial_out     <= 1'b1;
               send_req_ready <= 1'b1;
               r_tx_state     <= TX_IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------- RX path
   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   rx_state_t     r_rx_state;
   logic          r_rx_meta;
   logic          r_rx_s;
   logic          r_rx_prev;
   logic [7:0]    r_rx_shreg;
   logic [CW-1:0] r_rx_baud;
   logic [3:0]    r_rx_bit;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_rx_meta <= serial_in;
         r_rx_s    <= r_rx_meta;
         r_rx_prev <= r_rx_s;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_state     <= RX_IDLE;
         r_rx_shreg     <= '0;
         r_rx_baud      <= '0;
         r_rx_bit       <= '0;
         recv_rsp_data  <= 8'h00;
         recv_rsp_valid <= 1'b0;
      end else begin
         if (recv_rsp_valid && recv_rsp_ready)
            recv_rsp_valid <= 1'b0;

         case (r_rx_state)
            RX_IDLE: begin
               if (r_rx_prev && !r_rx_s) begin
                  r_rx_baud  <= '0;
                  r_rx_state <= RX_START;
               end
            end
            RX_START: begin
               if (r_rx_baud == HALF_LAST) begin
                  r_rx_baud  <= '0;
                  r_rx_bit   <= '0;
                  r_rx_state <= r_rx_s ? RX_IDLE : RX_DATA;
               end else begin
                  r_rx_baud <= r_rx_baud + CW'(1);
               end
            end
            RX_DATA: begin
               if (r_rx_baud == SYM_LAST) begin
                  r_rx_baud  <= '0;
                  r_rx_shreg <= {r_rx_s, r_rx_shreg[7:1]};
                  r_rx_bit   <= r_rx_bit + 4'd1;
                  if (r_rx_bit == 4'd7)
                     r_rx_state <= RX_STOP;
               end else begin
                  r_rx_baud <= r_rx_baud + CW'(1);
               end
            end
            RX_STOP: begin
               if (r_rx_baud == SYM_LAST) begin
                  r_rx_baud  <= '0;
                  r_rx_state <= RX_IDLE;
                  // Completion overrides a same-cycle handshake clear above
                  if (r_rx_s) begin
                     recv_rsp_data  <= r_rx_shreg;
                     recv_rsp_valid <= 1'b1;
                  end
               end else begin
                  r_rx_baud <= r_rx_baud + CW'(1);
               end
            end
            default: r_rx_state <= RX_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ama_riscv_uart.sv
//==============================================================================
// tb_ama_riscv_uart : scoreboard bench for the UART at SYM = 8, HALF = 4
// Revision: 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ama_riscv_uart;

   localparam int SYM = 8;
   localparam int LAT = 2 + 4 + 72 + 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] send_data = 8'h00;
   logic       send_valid = 1'b0;
   logic       send_ready;
   logic [7:0] rsp_data;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic       rx_drive = 1'b1;
   logic       loop_en = 1'b0;
   logic       serial_in;
   logic       serial_out;

   int         n_tests = 0;
   int         n_fail = 0;
   logic [7:0] sb[$];
   logic [7:0] last_data = 8'h00;
   logic       prev_valid = 1'b0;
   int         rise_cnt = 0;

   always #5 clk = ~clk;

   assign serial_in = loop_en ? serial_out : rx_drive;

   ama_riscv_uart #(.CLK_FREQ(800), .BAUD_RATE(100)) dut (
      .clk            (clk),
      .rst            (rst),
      .send_req_data  (send_data),
      .send_req_valid (send_valid),
      .send_req_ready (send_ready),
      .recv_rsp_data  (rsp_data),
      .recv_rsp_valid (rsp_valid),
      .recv_rsp_ready (rsp_ready),
      .serial_in      (serial_in),
      .serial_out     (serial_out)
   );

   always @(posedge clk) begin
      prev_valid <= rsp_valid;
      if (rsp_valid === 1'b1 && prev_valid !== 1'b1)
         rise_cnt <= rise_cnt + 1;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Drives one frame on serial_in starting this cycle; rdy_at pulses ready.
   task automatic drive_frame(input logic [7:0] b, input logic stop, input int rdy_at);
      logic [9:0] frame;
      frame = {stop, b, 1'b0};
      for (int i = 0; i < 10 * SYM; i++) begin
         rx_drive  = frame[i / SYM];
         rsp_ready = (i == rdy_at);
         tick();
      end
      rx_drive  = 1'b1;
      rsp_ready = 1'b0;
   endtask

   // Sends b through TX with serial_out looped to serial_in and checks receipt.
   task automatic loopback_byte(input logic [7:0] b);
      int         c;
      logic [7:0] exp;
      loop_en    = 1'b1;
      sb.push_back(b);
      send_data  = b;
      send_valid = 1'b1;
      tick();
      send_valid = 1'b0;
      n_tests++;
      if (serial_out !== 1'b0) begin
         n_fail++;
         $display("FAIL lb_start: serial_out=%b expected 0", serial_out);
      end
      c = 0;
      while (rsp_valid !== 1'b1 && c < 300) begin
         tick();
         c++;
      end
      n_tests++;
      if (c != LAT) begin
         n_fail++;
         $display("FAIL lb_latency: valid after %0d cycles expected %0d", c, LAT);
      end
      exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
      n_tests++;
      if (rsp_data !== exp) begin
         n_fail++;
         $display("FAIL lb_data: data=%h expected %h", rsp_data, exp);
      end
      last_data = exp;
      c = 0;
      while (send_ready !== 1'b1 && c < 100) begin
         tick();
         c++;
      end
      n_tests++;
      if (send_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL lb_tx_done: ready=%b expected 1", send_ready);
      end
      loop_en = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         send_valid = i[0];
         send_data  = 8'h5A ^ 8'(i);
         rx_drive   = i[0];
         rsp_ready  = ~i[0];
         tick();
      end
      rst = 1'b0; send_valid = 1'b0; rx_drive = 1'b1; rsp_ready = 1'b0;
      n_tests += 4;
      if (serial_out !== 1'b1) begin n_fail++; $display("FAIL rst_serial_out: %b expected 1", serial_out); end
      if (send_ready !== 1'b1) begin n_fail++; $display("FAIL rst_send_ready: %b expected 1", send_ready); end
      if (rsp_valid !== 1'b0)  begin n_fail++; $display("FAIL rst_rsp_valid: %b expected 0", rsp_valid); end
      if (rsp_data !== 8'h00)  begin n_fail++; $display("FAIL rst_rsp_data: %h expected 00", rsp_data); end
   endtask

   task automatic test_tx_a5;
      logic [9:0] frame;
      logic       quiet;
      frame      = {1'b1, 8'hA5, 1'b0};
      send_data  = 8'hA5;
      send_valid = 1'b1;
      tick();
      for (int i = 0; i < 10 * SYM; i++) begin
         send_valid = (i == 36);
         send_data  = (i == 36) ? 8'hFF : 8'hA5;
         n_tests += 2;
         if (serial_out !== frame[i / SYM]) begin
            n_fail++;
            $display("FAIL tx_bit cycle %0d: serial_out=%b expected %b", i, serial_out, frame[i / SYM]);
         end
         if (send_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL tx_ready_low cycle %0d: ready=%b expected 0", i, send_ready);
         end
         tick();
      end
      send_valid = 1'b0;
      n_tests += 2;
      if (send_ready !== 1'b1) begin n_fail++; $display("FAIL tx_ready_back: %b expected 1", send_ready); end
      if (serial_out !== 1'b1) begin n_fail++; $display("FAIL tx_idle_line: %b expected 1", serial_out); end
      quiet = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if (serial_out !== 1'b1 || send_ready !== 1'b1) quiet = 1'b0;
         tick();
      end
      n_tests++;
      if (quiet !== 1'b1) begin n_fail++; $display("FAIL tx_dropped_byte: line active=%b expected 0", ~quiet); end
   endtask

   task automatic test_loopback;
      logic held;
      loopback_byte(8'h3C);
      held = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (rsp_valid !== 1'b1) held = 1'b0;
      end
      n_tests++;
      if (held !== 1'b1) begin n_fail++; $display("FAIL lb_valid_hold: held=%b expected 1", held); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      n_tests += 2;
      if (rsp_valid !== 1'b0)   begin n_fail++; $display("FAIL lb_valid_clear: %b expected 0", rsp_valid); end
      if (rsp_data !== 8'h3C)   begin n_fail++; $display("FAIL lb_data_hold: %h expected 3c", rsp_data); end
   endtask

   task automatic test_glitch_framing;
      int         r0;
      logic [7:0] exp;
      r0 = rise_cnt;
      rx_drive = 1'b0;
      tick();
      tick();
      rx_drive = 1'b1;
      repeat (40) tick();
      n_tests++;
      if (rise_cnt != r0 || rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL glitch: valid rises=%0d valid=%b expected 0 and 0", rise_cnt - r0, rsp_valid);
      end
      drive_frame(8'h55, 1'b0, -1);
      repeat (20) tick();
      n_tests += 2;
      if (rise_cnt != r0 || rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL framing_valid: rises=%0d valid=%b expected 0 and 0", rise_cnt - r0, rsp_valid);
      end
      if (rsp_data !== last_data) begin
         n_fail++;
         $display("FAIL framing_data: %h expected %h", rsp_data, last_data);
      end
      sb.push_back(8'hC3);
      drive_frame(8'hC3, 1'b1, -1);
      exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp) begin
         n_fail++;
         $display("FAIL rx_recover: valid=%b data=%h expected 1 %h", rsp_valid, rsp_data, exp);
      end
      last_data = exp;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic test_overrun;
      logic [7:0] exp;
      sb.push_back(8'h11);
      drive_frame(8'h11, 1'b1, -1);
      sb.push_back(8'h22);
      drive_frame(8'h22, 1'b1, -1);
      while (sb.size() > 1) void'(sb.pop_front());
      exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp) begin
         n_fail++;
         $display("FAIL overrun: valid=%b data=%h expected 1 %h", rsp_valid, rsp_data, exp);
      end
      sb.push_back(8'h11);
      drive_frame(8'h11, 1'b1, -1);
      exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp) begin
         n_fail++;
         $display("FAIL overrun2: valid=%b data=%h expected 1 %h", rsp_valid, rsp_data, exp);
      end
      // Completion cycle of this frame is offset 78 from its start bit
      sb.push_back(8'h22);
      drive_frame(8'h22, 1'b1, 78);
      exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp) begin
         n_fail++;
         $display("FAIL simultaneous: valid=%b data=%h expected 1 %h", rsp_valid, rsp_data, exp);
      end
      last_data = exp;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      n_tests++;
      if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL overrun_clear: %b expected 0", rsp_valid); end
   endtask

   task automatic test_reset_midframe;
      int   r0;
      logic quiet;
      r0 = rise_cnt;
      send_data  = 8'h00;
      send_valid = 1'b1;
      tick();
      send_valid = 1'b0;
      repeat (9) tick();
      rx_drive = 1'b0;
      repeat (26) tick();
      n_tests++;
      if (serial_out !== 1'b0 || send_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_tx_active: serial_out=%b ready=%b expected 0 0", serial_out, send_ready);
      end
      rst      = 1'b1;
      rx_drive = 1'b1;
      tick();
      rst = 1'b0;
      n_tests++;
      if (serial_out !== 1'b1 || send_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_rst_outputs: serial_out=%b ready=%b valid=%b expected 1 1 0",
                  serial_out, send_ready, rsp_valid);
      end
      quiet = 1'b1;
      for (int i = 0; i < 120; i++) begin
         if (serial_out !== 1'b1) quiet = 1'b0;
         tick();
      end
      n_tests++;
      if (quiet !== 1'b1 || rise_cnt != r0) begin
         n_fail++;
         $display("FAIL mid_no_output: line_quiet=%b valid_rises=%0d expected 1 0", quiet, rise_cnt - r0);
      end
      loopback_byte(8'h7E);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_tx_a5();
      test_loopback();
      test_glitch_framing();
      test_overrun();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
